// File: rtl/fib_monitor.sv
// Checks a 4-bit stream against the repeating Fibonacci period 0,1,1,2,3,5,8.
// It locks on to a 0, tracks the sequence, and counts complete periods and mismatches.
module fib_monitor #(
  parameter int CNT_W  = 8,
  parameter bit RESYNC = 1'b1
) (
  input  logic             clock,
  input  logic             resete,
  input  logic [3:0]       entrada,
  input  logic             valido,
  output logic             sincronizado,
  output logic             erro,
  output logic [CNT_W-1:0] ciclos,
  output logic [CNT_W-1:0] falhas,
  output logic [6:0]       segmentos,
  output logic [1:0]       estado
);

  // Handshake: entrada is consumed on a posedge only when valido=1; there is no
  // backpressure, and with valido=0 every register holds its value.

  typedef enum logic [1:0] {
    BUSCA = 2'd0,
    SEGUE = 2'd1,
    ERRO  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  logic [2:0] idx;
  logic [2:0] idx_next;
  logic [3:0] expected;
  logic [6:0] pattern;

  always_comb idx_next = (idx == 3'd6) ? 3'd0 : idx + 3'd1;

  // Value the stream must show next while tracking.
  always_comb begin
    expected = 4'd0;
    case (idx_next)
      3'd0:       expected = 4'd0;
      3'd1, 3'd2: expected = 4'd1;
      3'd3:       expected = 4'd2;
      3'd4:       expected = 4'd3;
      3'd5:       expected = 4'd5;
      default:    expected = 4'd8;
    endcase
  end

  // Decimal font, segment a in bit 0; anything above 9 shows a dash.
  always_comb begin
    pattern = 7'h40;
    case (entrada)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h40;
    endcase
  end

  always_ff @(posedge clock or posedge resete) begin
    if (resete) begin
      state        <= BUSCA;
      idx          <= 3'd0;
      ciclos       <= '0;
      falhas       <= '0;
      segmentos    <= 7'h00;
      sincronizado <= 1'b0;
      erro         <= 1'b0;
    end else if (valido) begin
      segmentos <= pattern;
      case (state)
        BUSCA: begin
          if (entrada == 4'd0) begin
            state        <= SEGUE;
            idx          <= 3'd0;
            sincronizado <= 1'b1;
            erro         <= 1'b0;
          end
        end
        SEGUE: begin
          if (entrada == expected) begin
            idx <= idx_next;
            if (idx_next == 3'd6 && ciclos != CNT_MAX)
              ciclos <= ciclos + CNT_W'(1);
          end else begin
            state        <= ERRO;
            sincronizado <= 1'b0;
            erro         <= 1'b1;
            if (falhas != CNT_MAX)
              falhas <= falhas + CNT_W'(1);
          end
        end
        ERRO: begin
          if (RESYNC && entrada == 4'd0) begin
            state        <= SEGUE;
            idx          <= 3'd0;
            sincronizado <= 1'b1;
            erro         <= 1'b0;
          end
        end
        default: begin
          state        <= BUSCA;
          idx          <= 3'd0;
          sincronizado <= 1'b0;
          erro         <= 1'b0;
        end
      endcase
    end
  end

  assign estado = state;

endmodule
